// File: rtl/adc_spi_frame_capture.sv
// Capture engine for one dual-DOUT simultaneous-sampling SAR ADC: CONVST pulse, BUSY wait, parallel SPI read into a FIFO.
// Optional BUSY_TIMEOUT_EN adds a busy-wait timeout and a sticky timeout_err output.
`timescale 1ns/1ps

module adc_spi_frame_capture #(
   parameter int SCLK_HALF    = 2,
   parameter int SAMPLE_BITS  = 16,
   parameter int CH_PER_LINE  = 4,
   parameter int CONVST_CYC   = 4,
   parameter int RST_CYC      = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int BUSY_TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     trigger,
   output logic                     convst,
   output logic                     cs_n,
   output logic                     sclk,
   output logic                     adc_reset,
   input  logic                     busy,
   input  logic                     miso_0,
   input  logic                     miso_1,
   output logic [2*SAMPLE_BITS-1:0] out_data,
   output logic [1:0]               out_ch,
   output logic                     out_sop,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overrun,
`ifdef BUSY_TIMEOUT_EN
   output logic                     timeout_err,
`endif
   input  logic                     clr_err
);

   localparam int FRAME_BITS = CH_PER_LINE * SAMPLE_BITS;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int SB_W       = $clog2(SAMPLE_BITS);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W    = 2 * SAMPLE_BITS + 3;
   localparam int MAX_A      = (RST_CYC > CONVST_CYC) ? RST_CYC : CONVST_CYC;
   localparam int MAX_B      = (SCLK_HALF > BUSY_TIMEOUT) ? SCLK_HALF : BUSY_TIMEOUT;
   localparam int CNT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {POR, IDLE, CONV, WAIT_HI, WAIT_LO, SHIFT} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [CNT_W-1:0]       cnt;
   logic                   phase;
   logic [BIT_W-1:0]       bit_cnt;
   logic [SAMPLE_BITS-2:0] sr0;
   logic [SAMPLE_BITS-2:0] sr1;

   logic half_done;
   logic sample;
   logic last_bit;
   logic busy_timeout;

   assign half_done = (state == SHIFT) && (cnt == CNT_W'(SCLK_HALF - 1));
   assign sample    = half_done && !phase;
   assign last_bit  = half_done && phase && (bit_cnt == BIT_W'(FRAME_BITS - 1));

`ifdef BUSY_TIMEOUT_EN
   assign busy_timeout = (cnt == CNT_W'(BUSY_TIMEOUT - 1));
`else
   assign busy_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= POR;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         POR:     if (cnt == CNT_W'(RST_CYC - 1))    next_state = IDLE;
         IDLE:    if (trigger && enable)             next_state = CONV;
         CONV:    if (cnt == CNT_W'(CONVST_CYC - 1)) next_state = WAIT_HI;
         WAIT_HI: if (busy)                          next_state = WAIT_LO;
                  else if (busy_timeout)             next_state = IDLE;
         WAIT_LO: if (!busy)                         next_state = SHIFT;
                  else if (busy_timeout)             next_state = IDLE;
         SHIFT:   if (last_bit)                      next_state = IDLE;
         default:                                    next_state = POR;
      endcase
   end

   always_comb begin
      convst    = 1'b1;
      cs_n      = 1'b1;
      sclk      = 1'b1;
      adc_reset = 1'b0;
      case (state)
         POR:     adc_reset = 1'b1;
         CONV:    convst    = 1'b0;
         SHIFT: begin
            cs_n = 1'b0;
            sclk = phase;
         end
         default: ;
      endcase
   end

   // One counter times every state; it restarts on each state change so each wait gets its own budget.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         phase   <= 1'b0;
         bit_cnt <= '0;
         sr0     <= '0;
         sr1     <= '0;
      end else if (state != next_state) begin
         cnt     <= '0;
         phase   <= 1'b0;
         bit_cnt <= '0;
         sr0     <= '0;
         sr1     <= '0;
      end else if (half_done) begin
         cnt   <= '0;
         phase <= ~phase;
         if (phase) begin
            bit_cnt <= bit_cnt + 1'b1;
         end else begin
            sr0 <= {sr0[SAMPLE_BITS-3:0], miso_0};
            sr1 <= {sr1[SAMPLE_BITS-3:0], miso_1};
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   logic               push;
   logic [1:0]         push_ch;
   logic [ENTRY_W-1:0] push_entry;

   // The last bit of each word is taken straight from the pins so the word is pushed on its final sample edge.
   assign push       = sample && (bit_cnt[SB_W-1:0] == {SB_W{1'b1}});
   assign push_ch    = 2'(bit_cnt >> SB_W);
   assign push_entry = {(push_ch == 2'd0), push_ch, sr0, miso_0, sr1, miso_1};

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr;
   logic [PTR_W:0]     rd_ptr;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic               drop;
   logic [ENTRY_W-1:0] head;

   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop     = out_valid && out_ready;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign head    = mem[rd_ptr[PTR_W-1:0]];

   assign out_valid = (wr_ptr != rd_ptr);
   assign out_sop   = out_valid ? head[ENTRY_W-1] : 1'b0;
   assign out_ch    = out_valid ? head[ENTRY_W-2 -: 2] : 2'd0;
   assign out_data  = out_valid ? head[2*SAMPLE_BITS-1:0] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // A new error in the same cycle as clr_err wins.
   logic trig_missed;
   assign trig_missed = trigger && (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     overrun <= 1'b0;
      else if (drop || trig_missed)  overrun <= 1'b1;
      else if (clr_err)              overrun <= 1'b0;
   end

`ifdef BUSY_TIMEOUT_EN
   logic timeout_hit;
   assign timeout_hit = busy_timeout && (((state == WAIT_HI) && !busy) || ((state == WAIT_LO) && busy));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)            timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
      else if (clr_err)     timeout_err <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_adc_spi_frame_capture.sv
// Directed bench for adc_spi_frame_capture with a small dual-DOUT ADC model driven from sclk falling edges.
`timescale 1ns/1ps

module tb_adc_spi_frame_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic        busy = 1'b0;
   logic        miso_0 = 1'b0;
   logic        miso_1 = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_err = 1'b0;
   logic        convst;
   logic        cs_n;
   logic        sclk;
   logic        adc_reset;
   logic [31:0] out_data;
   logic [1:0]  out_ch;
   logic        out_sop;
   logic        out_valid;
   logic        overrun;
`ifdef BUSY_TIMEOUT_EN
   logic        timeout_err;
`endif

   int compared = 0;
   int mismatched = 0;
   int adcBit = 0;

   logic [63:0] line0 = 64'h1111_2222_3333_4444;
   logic [63:0] line1 = 64'hA0A0_A1A1_A2A2_A3A3;

   adc_spi_frame_capture dut (
      .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
      .convst(convst), .cs_n(cs_n), .sclk(sclk), .adc_reset(adc_reset),
      .busy(busy), .miso_0(miso_0), .miso_1(miso_1),
      .out_data(out_data), .out_ch(out_ch), .out_sop(out_sop),
      .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
`ifdef BUSY_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   // ADC model: presents the next MSB-first bit on each falling sclk edge.
   initial begin
      forever begin
         @(negedge sclk);
         if (adcBit < 64) begin
            miso_0 = line0[63 - adcBit];
            miso_1 = line1[63 - adcBit];
            adcBit++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit midTrig, input int abortAt, output int convLow, output int csLow);
      int guard;
      adcBit = 0;
      @(negedge clk) trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      convLow = 0;
      while (!convst && convLow < 50) begin
         convLow++;
         @(negedge clk);
      end
      busy = 1'b1;
      repeat (10) @(negedge clk);
      busy = 1'b0;
      guard = 0;
      while (cs_n && guard < 20) begin
         guard++;
         @(negedge clk);
      end
      csLow = 0;
      while (!cs_n && csLow < 1000) begin
         if (abortAt != 0 && csLow == abortAt) begin
            checkOutput("valid before abort", 64'(out_valid), 64'd1);
            reset = 1'b1;
            #1;
            checkOutput("abort cs_n", 64'(cs_n), 64'd1);
            checkOutput("abort sclk", 64'(sclk), 64'd1);
            checkOutput("abort out_valid", 64'(out_valid), 64'd0);
            checkOutput("abort adc_reset", 64'(adc_reset), 64'd1);
            break;
         end
         trigger = (midTrig && csLow == 100);
         csLow++;
         @(negedge clk);
      end
      trigger = 1'b0;
   endtask

   task automatic popWord(input int k, input string tag);
      logic [31:0] expData;
      expData = {line0[63 - 16*k -: 16], line1[63 - 16*k -: 16]};
      checkOutput({tag, " valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, " data"}, 64'(out_data), 64'(expData));
      checkOutput({tag, " ch"}, 64'(out_ch), 64'(k));
      checkOutput({tag, " sop"}, 64'(out_sop), 64'(k == 0));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic countPor(input string tag);
      int n;
      n = 0;
      while (adc_reset && n < 50) begin
         n++;
         @(negedge clk);
      end
      checkOutput(tag, 64'(n), 64'd8);
   endtask

   initial begin
      int cv;
      int cs;
      repeat (3) @(negedge clk);
      checkOutput("rst convst", 64'(convst), 64'd1);
      checkOutput("rst cs_n", 64'(cs_n), 64'd1);
      checkOutput("rst sclk", 64'(sclk), 64'd1);
      checkOutput("rst adc_reset", 64'(adc_reset), 64'd1);
      checkOutput("rst out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst out_data", 64'(out_data), 64'd0);
      checkOutput("rst out_ch", 64'({out_sop, out_ch}), 64'd0);
      checkOutput("rst overrun", 64'(overrun), 64'd0);

      reset = 1'b0;
      countPor("por width");
      repeat (5) @(negedge clk);
      checkOutput("idle lines", 64'({convst, cs_n, sclk, adc_reset}), 64'b1110);

      // Trigger while disabled must be ignored without flagging an error.
      trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      checkOutput("disabled convst", 64'(convst), 64'd1);
      checkOutput("disabled overrun", 64'(overrun), 64'd0);

      enable = 1'b1;
      applyStimulus(1'b0, 0, cv, cs);
      checkOutput("convst width", 64'(cv), 64'd4);
      checkOutput("cs_n width", 64'(cs), 64'd256);
      for (int k = 0; k < 4; k++) popWord(k, "f1");
      checkOutput("f1 drained", 64'(out_valid), 64'd0);
      checkOutput("f1 overrun", 64'(overrun), 64'd0);

      // Three frames with no consumer: 12 words into 8 slots.
      for (int f = 0; f < 3; f++) applyStimulus(1'b0, 0, cv, cs);
      checkOutput("ovr flag", 64'(overrun), 64'd1);
      for (int i = 0; i < 8; i++) popWord(i % 4, "ovr");
      checkOutput("ovr drained", 64'(out_valid), 64'd0);
      clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
      checkOutput("ovr cleared", 64'(overrun), 64'd0);

      applyStimulus(1'b1, 0, cv, cs);
      checkOutput("midtrig cs_n width", 64'(cs), 64'd256);
      checkOutput("midtrig overrun", 64'(overrun), 64'd1);
      for (int k = 0; k < 4; k++) popWord(k, "mt");
      repeat (20) @(negedge clk);
      checkOutput("midtrig no frame", 64'({out_valid, convst, cs_n}), 64'b011);
      clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;

      applyStimulus(1'b0, 80, cv, cs);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      countPor("por after abort");
      checkOutput("abort fifo empty", 64'(out_valid), 64'd0);
      checkOutput("abort overrun", 64'(overrun), 64'd0);
      applyStimulus(1'b0, 0, cv, cs);
      checkOutput("recovery cs_n width", 64'(cs), 64'd256);
      for (int k = 0; k < 4; k++) popWord(k, "rc");

`ifdef BUSY_TIMEOUT_EN
      begin
         bit csSeen;
         csSeen = 1'b0;
         @(negedge clk) trigger = 1'b1;
         @(negedge clk) trigger = 1'b0;
         for (int i = 0; i < 4300; i++) begin
            if (!cs_n) csSeen = 1'b1;
            @(negedge clk);
         end
         checkOutput("timeout err", 64'(timeout_err), 64'd1);
         checkOutput("timeout no cs", 64'(csSeen), 64'd0);
         checkOutput("timeout idle", 64'({convst, out_valid}), 64'b10);
         clr_err = 1'b1;
         @(negedge clk) clr_err = 1'b0;
         checkOutput("timeout cleared", 64'(timeout_err), 64'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
